// File: rtl/seq_mul_pkg.sv
// ----------------------------------------------------------------------------
// seq_mul_pkg
// Shared definitions for the sequential digit-serial multiplier:
//   - state_t     : FSM state encoding (IDLE / CALC / DONE)
//   - DIGITS_DEF  : default number of 2-bit digits per operand
//   - CALC_CYCLES : number of CALC cycles for the default digit count
//   - idx_width() : width of a digit index counter (never less than 1)
// ----------------------------------------------------------------------------
package seq_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIGITS_DEF  = 2;
    localparam int CALC_CYCLES = DIGITS_DEF * DIGITS_DEF;

    // A single-digit operand still needs a 1-bit index register.
    function automatic int idx_width(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/seq_mul4x4_mul2x2.sv
// ----------------------------------------------------------------------------
// mul2x2
// Combinational 2-bit x 2-bit -> 4-bit unsigned digit multiplier.
// Ports:
//   i_a [1:0] : multiplicand digit
//   i_b [1:0] : multiplier digit
//   o_p [3:0] : product
// ----------------------------------------------------------------------------
module mul2x2 (
    input  logic [1:0] i_a,
    input  logic [1:0] i_b,
    output logic [3:0] o_p
);

    // Two shifted partial products of a 2-bit multiplicand.
    logic [3:0] w_pp0;
    logic [3:0] w_pp1;

    assign w_pp0 = i_b[0] ? {2'b00, i_a}       : 4'd0;
    assign w_pp1 = i_b[1] ? {1'b0, i_a, 1'b0}  : 4'd0;
    assign o_p   = w_pp0 + w_pp1;

endmodule

// File: rtl/seq_mul4x4.sv
// ----------------------------------------------------------------------------
// seq_mul4x4
// Sequential unsigned multiplier. Each operand is split into 2-bit digits;
// one digit pair per cycle goes through a shared mul2x2 and the shifted
// partial product is added into a 2W-bit accumulator.
//
// Parameters:
//   DIGITS    : 2-bit digits per operand (W = 2*DIGITS, product is 2W bits)
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   in_valid  : operands present on a_in / b_in
//   in_ready  : block can accept operands (IDLE only)
//   a_in      : multiplicand [W-1:0]
//   b_in      : multiplier   [W-1:0]
//   out_valid : product valid (DONE only)
//   out_ready : consumer accepts product
//   product   : result [2W-1:0], changes only when entering DONE
//   busy      : state is not IDLE
//
// Build option:
//   SEQ_MUL_ZERO_SKIP_EN : when defined, a zero operand at accept goes
//                          straight to DONE with a zero result (latency 1).
// ----------------------------------------------------------------------------
module seq_mul4x4
    import seq_mul_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*DIGITS-1:0]   a_in,
    input  logic [2*DIGITS-1:0]   b_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   product,
    output logic                  busy
);

    localparam int W      = 2 * DIGITS;
    localparam int PROD_W = 2 * W;
    localparam int IDX_W  = idx_width(DIGITS);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [W-1:0]        r_a;
    logic [W-1:0]        r_b;
    logic [PROD_W-1:0]   r_acc;
    logic [PROD_W-1:0]   r_product;
    logic [IDX_W-1:0]    r_i;
    logic [IDX_W-1:0]    r_j;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_busy;

    // ------------------------------------------------------------------
    // Digit select, shared digit multiplier, shift-add
    // ------------------------------------------------------------------
    logic [1:0]          w_a_dig;
    logic [1:0]          w_b_dig;
    logic [3:0]          w_pp;
    logic [IDX_W+1:0]    w_shift;
    logic [PROD_W-1:0]   w_pp_shifted;
    logic [PROD_W-1:0]   w_acc_next;
    logic                w_last_pair;

    assign w_a_dig = r_a[{r_i, 1'b0} +: 2];
    assign w_b_dig = r_b[{r_j, 1'b0} +: 2];

    mul2x2 u_mul2x2 (
        .i_a (w_a_dig),
        .i_b (w_b_dig),
        .o_p (w_pp)
    );

    // Digit pair (i, j) carries weight 4^(i+j), i.e. a shift of 2*(i+j).
    assign w_shift      = {1'b0, r_i, 1'b0} + {1'b0, r_j, 1'b0};
    assign w_pp_shifted = PROD_W'(w_pp) << w_shift;
    assign w_acc_next   = r_acc + w_pp_shifted;
    assign w_last_pair  = (r_i == LAST_IDX) && (r_j == LAST_IDX);

`ifdef SEQ_MUL_ZERO_SKIP_EN
    logic w_zero_op;
    assign w_zero_op = (a_in == '0) || (b_in == '0);
`endif

    // ------------------------------------------------------------------
    // FSM with registered handshake/status outputs
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // in this block samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            // NOTE: the operand registers are reset too; they are few flops and
            // a known value keeps the digit muxes free of X after reset.
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_product   <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // in_ready is 1 throughout IDLE, so in_valid alone is the accept.
                    if (in_valid) begin
                        r_a        <= a_in;
                        r_b        <= b_in;
                        r_acc      <= '0;
                        r_i        <= '0;
                        r_j        <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
`ifdef SEQ_MUL_ZERO_SKIP_EN
                        if (w_zero_op) begin
                            r_state     <= DONE;
                            r_product   <= '0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state     <= CALC;
                        end
`else
                        r_state    <= CALC;
`endif
                    end
                end

                CALC: begin
                    r_acc <= w_acc_next;
                    if (w_last_pair) begin
                        r_state     <= DONE;
                        r_product   <= w_acc_next;
                        r_out_valid <= 1'b1;
                        r_i         <= '0;
                        r_j         <= '0;
                    end else if (r_j == LAST_IDX) begin
                        r_j <= '0;
                        r_i <= r_i + IDX_W'(1);
                    end else begin
                        r_j <= r_j + IDX_W'(1);
                    end
                end

                DONE: begin
                    // out_valid is 1 throughout DONE, so out_ready alone is the handshake.
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end

                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign product   = r_product;
    assign busy      = r_busy;

endmodule
